// File: rtl/ram_prog_store.sv
// ram_prog_store: program/data RAM for the 8-bit CPU.
// Holds a memory address register (MAR) and a 2^ADDR_W x DATA_W array.
// In run mode the CPU drives it from the shared bus on each tick.
// In program mode the user fills it from switches and a push-button.
//
// Optional build macro PROG_AUTOINC_EN:
//   - On entry to program mode, MAR is loaded from prog_addr.
//   - Each program-mode write goes to MAR, then MAR increments (with wrap).
//   - Without the macro, program-mode writes go to prog_addr.
//     In that build, MAR is left alone while in program mode.
module ram_prog_store #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              tick,
  input  logic              prog_mode,
  input  logic [ADDR_W-1:0] prog_addr,
  input  logic [DATA_W-1:0] prog_data,
  input  logic              prog_btn,
  input  logic              mar_load,
  input  logic              ram_load,
  input  logic              ram_out,
  input  logic [DATA_W-1:0] bus_in,
  output logic [DATA_W-1:0] bus_out,
  output logic              bus_drive,
  output logic [ADDR_W-1:0] mar_q,
  output logic              prog_ack,
  output logic              err
);

  localparam int DEPTH = 1 << ADDR_W;

  logic              mode_s1_reg;
  logic              mode_s2_reg;
  logic              btn_s1_reg;
  logic              btn_s2_reg;
  logic              btn_s3_reg;
  logic              mode_s;
  logic              btn_pulse;
  logic [ADDR_W-1:0] mar_reg;
  logic [ADDR_W-1:0] addr_sel;
  logic [ADDR_W-1:0] rd_addr;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic [DATA_W-1:0] rd_q_reg;
  logic              bus_drive_reg;
  logic              err_reg;
  logic              run_tick;
  logic              run_write;
  logic              run_conflict;
  logic              prog_write;
  logic              mem_we;
  logic [DATA_W-1:0] mem [DEPTH];

  // Two-flop synchronisers for the raw switch and button.
  // The button also gets a third flop, used for rising-edge detection.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mode_s1_reg <= 1'b0;
      mode_s2_reg <= 1'b0;
      btn_s1_reg  <= 1'b0;
      btn_s2_reg  <= 1'b0;
      btn_s3_reg  <= 1'b0;
    end else begin
      mode_s1_reg <= prog_mode;
      mode_s2_reg <= mode_s1_reg;
      btn_s1_reg  <= prog_btn;
      btn_s2_reg  <= btn_s1_reg;
      btn_s3_reg  <= btn_s2_reg;
    end
  end

  assign mode_s    = mode_s2_reg;
  assign btn_pulse = btn_s2_reg & ~btn_s3_reg;

  // Bus controls only act on a tick in run mode.
  // A load and an out on the same tick is a bus fight, so that write is refused.
  assign run_tick     = tick & ~mode_s;
  assign run_write    = run_tick & ram_load & ~ram_out;
  assign run_conflict = run_tick & ram_load & ram_out;
  // A button pulse is dropped unless the mode is already program.
  assign prog_write   = btn_pulse & mode_s;

`ifdef PROG_AUTOINC_EN
  logic mode_d_reg;
  logic prog_first;

  // Delayed mode, used to find the first program-mode cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) mode_d_reg <= 1'b0;
    else        mode_d_reg <= mode_s;
  end

  assign prog_first = mode_s & ~mode_d_reg;
  assign addr_sel   = mar_reg;
`else
  assign addr_sel   = prog_addr;
`endif

  // MAR: loaded from the bus low bits in run mode; optionally auto-increments in program mode.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mar_reg <= '0;
    end else if (run_tick && mar_load) begin
      mar_reg <= bus_in[ADDR_W-1:0];
    end
`ifdef PROG_AUTOINC_EN
    else if (prog_first) begin
      mar_reg <= prog_addr;
    end else if (prog_write) begin
      mar_reg <= mar_reg + ADDR_W'(1);
    end
`endif
  end

  // A run-mode write uses the MAR value from before this edge, even if MAR is also loading.
  // Gating with rst_n blocks a write on an edge that lands while reset is held.
  assign mem_we  = (run_write | prog_write) & rst_n;
  assign wr_addr = mode_s ? addr_sel : mar_reg;
  assign wr_data = mode_s ? prog_data : bus_in;
  assign rd_addr = mode_s ? addr_sel : mar_reg;

  // Memory array write port; contents are deliberately not reset.
  always_ff @(posedge clk) begin
    if (mem_we) mem[wr_addr] <= wr_data;
  end

  // Registered read on every edge, plus bus-drive enable and sticky conflict flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_q_reg      <= '0;
      bus_drive_reg <= 1'b0;
      err_reg       <= 1'b0;
    end else begin
      rd_q_reg      <= mem[rd_addr];
      bus_drive_reg <= ram_out & ~mode_s;
      if (run_conflict) err_reg <= 1'b1;
    end
  end

  assign bus_drive = bus_drive_reg;
  assign bus_out   = bus_drive_reg ? rd_q_reg : '0;
  assign mar_q     = mar_reg;
  assign prog_ack  = prog_write;
  assign err       = err_reg;

endmodule

// File: tb/tb_ram_prog_store.sv
// Testbench for ram_prog_store (DATA_W = 8, ADDR_W = 4).
// Checks the design against a behavioural memory/MAR model kept in this bench.
// Build with PROG_AUTOINC_EN defined to also cover the auto-increment variant.
`timescale 1ns/1ps
module tb_ram_prog_store;
  localparam int DATA_W = 8;
  localparam int ADDR_W = 4;
  localparam int DEPTH  = 16;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              tick = 1'b0;
  logic              prog_mode = 1'b0;
  logic [ADDR_W-1:0] prog_addr = '0;
  logic [DATA_W-1:0] prog_data = '0;
  logic              prog_btn = 1'b0;
  logic              mar_load = 1'b0;
  logic              ram_load = 1'b0;
  logic              ram_out = 1'b0;
  logic [DATA_W-1:0] bus_in = '0;
  logic [DATA_W-1:0] bus_out;
  logic              bus_drive;
  logic [ADDR_W-1:0] mar_q;
  logic              prog_ack;
  logic              err;

  int compared = 0;
  int mismatched = 0;

  // Reference model state
  logic [7:0] m_mem [DEPTH];
  logic [3:0] m_mar = '0;
  logic       m_err = 1'b0;
  bit         m_prog = 1'b0;
  bit         autoinc = 1'b0;

  ram_prog_store #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst_n(rst_n), .tick(tick), .prog_mode(prog_mode),
    .prog_addr(prog_addr), .prog_data(prog_data), .prog_btn(prog_btn),
    .mar_load(mar_load), .ram_load(ram_load), .ram_out(ram_out),
    .bus_in(bus_in), .bus_out(bus_out), .bus_drive(bus_drive),
    .mar_q(mar_q), .prog_ack(prog_ack), .err(err)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One CPU tick with the given controls, followed by an idle cycle.
  task automatic run_tick(input bit ml, input bit rl, input bit ro, input logic [7:0] b);
    mar_load = ml; ram_load = rl; ram_out = ro; bus_in = b; tick = 1'b1;
    step();
    tick = 1'b0; mar_load = 1'b0; ram_load = 1'b0; ram_out = 1'b0;
    bus_in = 8'($urandom);
    if (!m_prog) begin
      if (rl && ro) m_err = 1'b1;
      else if (rl) m_mem[m_mar] = b;
      if (ml) m_mar = b[3:0];
    end
    $display("txn tick ml=%0d rl=%0d ro=%0d bus=%h -> mar_q=%h", ml, rl, ro, b, mar_q);
    step();
  endtask

  // Drive ram_out for one cycle and compare the bus against the model, then release.
  task automatic check_read(input string name);
    logic [7:0] exp;
    exp = m_mem[m_mar];
    ram_out = 1'b1;
    step();
    compared++;
    if (bus_out !== exp || bus_drive !== 1'b1) begin
      mismatched++;
      $display("FAIL %s: bus_out=%h drive=%0b expected %h drive=1", name, bus_out, bus_drive, exp);
    end
    $display("txn read addr=%h bus_out=%h", m_mar, bus_out);
    ram_out = 1'b0;
    step();
    compared++;
    if (bus_out !== 8'h00) begin
      mismatched++;
      $display("FAIL %s_release: bus_out=%h expected 00", name, bus_out);
    end
  endtask

  task automatic set_mode(input bit p, input logic [3:0] addr);
    prog_addr = addr;
    prog_mode = p;
    repeat (4) step();
    m_prog = p;
    if (p && autoinc) m_mar = addr;
    $display("txn mode prog=%0d addr=%h", p, addr);
  endtask

  // Hold the button for 'hold' cycles, release it, and count prog_ack pulses.
  task automatic prog_press(input string name, input logic [3:0] addr,
                            input logic [7:0] data, input int hold);
    int acks;
    int exp_acks;
    acks = 0;
    prog_addr = addr; prog_data = data; prog_btn = 1'b1;
    repeat (hold) begin
      step();
      if (prog_ack === 1'b1) acks++;
    end
    prog_btn = 1'b0;
    repeat (4) begin
      step();
      if (prog_ack === 1'b1) acks++;
    end
    exp_acks = m_prog ? 1 : 0;
    if (m_prog) begin
      if (autoinc) begin
        m_mem[m_mar] = data;
        m_mar = m_mar + 4'd1;
      end else begin
        m_mem[addr] = data;
      end
    end
    $display("txn press addr=%h data=%h acks=%0d", addr, data, acks);
    compared++;
    if (acks != exp_acks) begin
      mismatched++;
      $display("FAIL %s: prog_ack pulses=%0d expected %0d", name, acks, exp_acks);
    end
  endtask

  task automatic test_reset();
    ram_out = 1'b1;
    #12;
    compared++;
    if (bus_out !== 8'h00 || bus_drive !== 1'b0) begin
      mismatched++;
      $display("FAIL reset_bus: bus_out=%h drive=%0b expected 00 0", bus_out, bus_drive);
    end
    compared++;
    if (mar_q !== 4'h0) begin
      mismatched++;
      $display("FAIL reset_mar: mar_q=%h expected 0", mar_q);
    end
    compared++;
    if (err !== 1'b0 || prog_ack !== 1'b0) begin
      mismatched++;
      $display("FAIL reset_flags: err=%0b prog_ack=%0b expected 0 0", err, prog_ack);
    end
    ram_out = 1'b0;
    #11;
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_run_basic();
    run_tick(1'b1, 1'b0, 1'b0, 8'h13);
    compared++;
    if (mar_q !== 4'h3) begin
      mismatched++;
      $display("FAIL mar_load_wrap: mar_q=%h expected 3", mar_q);
    end
    run_tick(1'b0, 1'b1, 1'b0, 8'hA5);
    check_read("run_read_a5");
  endtask

  task automatic test_same_tick();
    run_tick(1'b1, 1'b0, 1'b0, 8'h05);
    run_tick(1'b1, 1'b1, 1'b0, 8'h07);
    compared++;
    if (mar_q !== 4'h7) begin
      mismatched++;
      $display("FAIL same_tick_mar: mar_q=%h expected 7", mar_q);
    end
    run_tick(1'b1, 1'b0, 1'b0, 8'h05);
    check_read("same_tick_mem5");
  endtask

  task automatic test_back_to_back();
    // Write then read the same address on the very next edge.
    ram_load = 1'b1; bus_in = 8'h6E; tick = 1'b1;
    step();
    tick = 1'b0; ram_load = 1'b0; ram_out = 1'b1;
    m_mem[m_mar] = 8'h6E;
    step();
    compared++;
    if (bus_out !== 8'h6E) begin
      mismatched++;
      $display("FAIL write_then_read: bus_out=%h expected 6e", bus_out);
    end
    ram_out = 1'b0;
    step();
    // MAR change, then read on the next edge.
    mar_load = 1'b1; bus_in = 8'h03; tick = 1'b1;
    step();
    tick = 1'b0; mar_load = 1'b0; ram_out = 1'b1;
    m_mar = 4'h3;
    step();
    compared++;
    if (bus_out !== 8'hA5) begin
      mismatched++;
      $display("FAIL mar_then_read: bus_out=%h expected a5", bus_out);
    end
    ram_out = 1'b0;
    step();
  endtask

  task automatic test_program();
    set_mode(1'b1, 4'hF);
    ram_out = 1'b1;
    step();
    step();
    compared++;
    if (bus_out !== 8'h00 || bus_drive !== 1'b0) begin
      mismatched++;
      $display("FAIL prog_bus_masked: bus_out=%h drive=%0b expected 00 0", bus_out, bus_drive);
    end
    ram_out = 1'b0;
    mar_load = 1'b1; ram_load = 1'b1; bus_in = 8'h9A; tick = 1'b1;
    step();
    tick = 1'b0; mar_load = 1'b0; ram_load = 1'b0;
    step();
    compared++;
    if (mar_q !== m_mar) begin
      mismatched++;
      $display("FAIL prog_tick_masked: mar_q=%h expected %h", mar_q, m_mar);
    end
    prog_press("prog_held_1000", 4'hF, 8'h3C, 1000);
    set_mode(1'b0, 4'h0);
    run_tick(1'b1, 1'b0, 1'b0, 8'h0F);
    check_read("prog_readback_f");
  endtask

  task automatic test_dropped_btn();
    run_tick(1'b1, 1'b0, 1'b0, 8'h02);
    run_tick(1'b0, 1'b1, 1'b0, 8'h11);
    prog_press("run_btn_dropped", 4'h2, 8'hEE, 6);
    check_read("run_btn_mem2");
  endtask

  task automatic test_conflict();
    run_tick(1'b0, 1'b1, 1'b1, 8'h55);
    compared++;
    if (err !== 1'b1) begin
      mismatched++;
      $display("FAIL conflict_err: err=%0b expected 1", err);
    end
    check_read("conflict_mem2");
    compared++;
    if (err !== 1'b1) begin
      mismatched++;
      $display("FAIL err_sticky: err=%0b expected 1", err);
    end
  endtask

`ifdef PROG_AUTOINC_EN
  task automatic test_autoinc();
    set_mode(1'b1, 4'hE);
    prog_press("autoinc_p1", 4'h0, 8'h01, 5);
    prog_press("autoinc_p2", 4'h0, 8'h02, 5);
    prog_press("autoinc_p3", 4'h0, 8'h03, 5);
    compared++;
    if (mar_q !== 4'h1) begin
      mismatched++;
      $display("FAIL autoinc_mar: mar_q=%h expected 1", mar_q);
    end
    set_mode(1'b0, 4'h0);
    compared++;
    if (mar_q !== 4'h1) begin
      mismatched++;
      $display("FAIL autoinc_retain: mar_q=%h expected 1", mar_q);
    end
    run_tick(1'b1, 1'b0, 1'b0, 8'h0E);
    check_read("autoinc_mem14");
    run_tick(1'b1, 1'b0, 1'b0, 8'h0F);
    check_read("autoinc_mem15");
    run_tick(1'b1, 1'b0, 1'b0, 8'h00);
    check_read("autoinc_mem0");
  endtask
`endif

  task automatic test_random();
    int op;
    logic [7:0] b;
    for (int a = 0; a < DEPTH; a++) begin
      b = 8'($urandom);
      run_tick(1'b1, 1'b0, 1'b0, {b[7:4], 4'(a)});
      run_tick(1'b0, 1'b1, 1'b0, 8'($urandom));
    end
    for (int n = 0; n < 150; n++) begin
      op = int'($urandom_range(0, 4));
      b = 8'($urandom);
      case (op)
        0, 2: begin
          run_tick(1'b1, op == 2, 1'b0, b);
          compared++;
          if (mar_q !== m_mar) begin
            mismatched++;
            $display("FAIL rand_mar: mar_q=%h expected %h", mar_q, m_mar);
          end
        end
        1: run_tick(1'b0, 1'b1, 1'b0, b);
        3: check_read("rand_read");
        default: begin
          // Controls without tick must be ignored.
          mar_load = 1'b1; ram_load = 1'b1; bus_in = b; tick = 1'b0;
          step();
          mar_load = 1'b0; ram_load = 1'b0;
          compared++;
          if (mar_q !== m_mar) begin
            mismatched++;
            $display("FAIL rand_no_tick: mar_q=%h expected %h", mar_q, m_mar);
          end
        end
      endcase
    end
    for (int a = 0; a < DEPTH; a++) begin
      run_tick(1'b1, 1'b0, 1'b0, 8'(a));
      check_read("rand_sweep");
    end
  endtask

  task automatic test_reset_mid();
    run_tick(1'b1, 1'b0, 1'b0, 8'h0B);
    ram_out = 1'b1;
    step();
    #3;
    rst_n = 1'b0;
    #1;
    m_mar = 4'h0;
    m_err = 1'b0;
    compared++;
    if (bus_out !== 8'h00 || bus_drive !== 1'b0) begin
      mismatched++;
      $display("FAIL async_reset_bus: bus_out=%h drive=%0b expected 00 0", bus_out, bus_drive);
    end
    compared++;
    if (mar_q !== 4'h0 || err !== 1'b0) begin
      mismatched++;
      $display("FAIL async_reset_state: mar_q=%h err=%0b expected 0 0", mar_q, err);
    end
    ram_out = 1'b0;
    step();
    rst_n = 1'b1;
    step();
    run_tick(1'b1, 1'b0, 1'b0, 8'h0B);
    check_read("mem_kept_over_reset");
  endtask

  initial begin
`ifdef PROG_AUTOINC_EN
    autoinc = 1'b1;
`endif
    test_reset();
    test_run_basic();
    test_same_tick();
    test_back_to_back();
    test_program();
    test_dropped_btn();
    test_conflict();
`ifdef PROG_AUTOINC_EN
    test_autoinc();
`endif
    test_random();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/ram_prog_store.md
# ram_prog_store

Parametrised RAM for the 8-bit CPU: a memory address register (MAR) plus a 2^ADDR_W × DATA_W array. In run mode the CPU controls it from the shared bus on each tick of the CPU clock-enable. In program mode the user fills it from switches and a push-button. It replaces the fixed single-byte register stage and sits between the bus and the control sequencer, on the same 100 MHz `clk` as the clock timer.

## Interface

Parameters:
- DATA_W, 8, word and bus width (≥1)
- ADDR_W, 4, address width; depth = 2^ADDR_W (≥1, ≤ DATA_W)

Ports:
- clk  in  1  100 MHz system clock; all state on rising edge
- rst_n  in  1  reset, asynchronous assert, active-low
- tick  in  1  CPU clock-enable, one `clk` wide; never high in two consecutive cycles
- prog_mode  in  1  raw switch; 1 = program mode
- prog_addr  in  ADDR_W  switch address for program mode
- prog_data  in  DATA_W  switch data for program mode
- prog_btn  in  1  raw write push-button, level, unsynchronised
- mar_load  in  1  run mode: load MAR from bus_in[ADDR_W-1:0] on tick
- ram_load  in  1  run mode: write bus_in to mem[MAR] on tick
- ram_out  in  1  run mode: drive bus_out
- bus_in  in  DATA_W  shared bus value
- bus_out  out  DATA_W  read data; all zeros when bus_drive = 0
- bus_drive  out  1  ram_out & run mode (synchronised)
- mar_q  out  ADDR_W  current MAR, for LEDs
- prog_ack  out  1  one-cycle pulse on each program-mode write
- err  out  1  sticky conflict flag

Clock is `clk`. Reset is `rst_n`: one clock, asynchronous, active-low.

## Operation

- prog_mode and prog_btn each pass through a 2-flop synchroniser. The button gets a third flop; btn_pulse = s2 & ~s3.
- Mode is taken from synchronised prog_mode (mode_s).
- Run mode (mode_s = 0), on a `clk` edge with tick = 1:
  - mar_load: MAR ← bus_in[ADDR_W-1:0].
  - ram_load: mem[MAR] ← bus_in, using the MAR value before this edge when mar_load is also high.
  - ram_load & ram_out together: no write; err ← 1.
  - Controls are ignored while tick = 0.
- Program mode (mode_s = 1):
  - mar_load, ram_load and ram_out are masked; bus_drive = 0.
  - On btn_pulse: mem[addr_sel] ← prog_data; prog_ack = btn_pulse.
  - addr_sel = prog_addr (see Configuration).
- Read path: rd_q ← mem[rd_addr] every `clk` edge, regardless of tick.
  - rd_addr = MAR in run mode, addr_sel in program mode.
  - bus_out = bus_drive ? rd_q : 0.
- err clears only on reset.
- Memory contents are not reset.

## Timing

- Reset values: MAR = 0, rd_q = 0, all synchroniser flops = 0, err = 0, bus_out = 0, bus_drive = 0, prog_ack = 0, mode = run.
- Reset asserted mid-write: the array write is suppressed; in-flight button history is discarded.
- Read latency: 1 `clk` after a MAR change or write to the same address. rd_q is then valid before the next tick, which is guaranteed by the tick spacing rule. Write-then-read of the same address returns new data one cycle later.
- Button timing: raw rise sampled at edge 0, s2 = 1 after edge 1, prog_ack high for the cycle between edges 1 and 2, write at edge 2.
- A held button produces exactly one write; release and re-press are required for another.
- Mode change takes effect 2 `clk` after the raw switch edge. A btn_pulse that coincides with mode_s = 0 is dropped.
- Address wrap: MAR is ADDR_W bits; upper bus_in bits are discarded.

## Configuration

- PROG_AUTOINC_EN defined:
  - On the first cycle mode_s is 1, MAR ← prog_addr.
  - In program mode addr_sel = MAR; each program write increments MAR modulo 2^ADDR_W, so 2^ADDR_W − 1 wraps to 0.
  - MAR retains its value on return to run mode.
- PROG_AUTOINC_EN undefined:
  - addr_sel = prog_addr; MAR is untouched in program mode.

## Test plan

- Reset: rst_n = 0 mid-cycle → bus_out = 0, mar_q = 0, err = 0 immediately, asynchronously.
- Run write/read, DATA_W = 8, ADDR_W = 4:
  - tick with mar_load, bus_in = 0x13 → mar_q = 3.
  - tick with ram_load, bus_in = 0xA5.
  - ram_out = 1 → bus_out = 0xA5 one `clk` later; bus_out = 0 once ram_out drops.
- Program mode: prog_mode = 1, prog_addr = 0xF, prog_data = 0x3C, button held 1000 cycles → exactly one prog_ack, mem[15] = 0x3C; run-mode read of address 15 returns 0x3C.
- Conflict: tick with ram_load = ram_out = 1 at MAR = 2 holding 0x11 → mem[2] remains 0x11; err = 1 until reset.
- Same-tick load: mar_load and ram_load on one tick, MAR = 5, bus_in = 0x07 → mem[5] = 0x07, mar_q = 7.
- With PROG_AUTOINC_EN: prog_addr = 14, three presses with data 0x01/0x02/0x03 → mem[14] = 1, mem[15] = 2, mem[0] = 3; mar_q = 1.
